// File: rtl/trace_tx_scheduler.sv
// rtl/trace_tx_scheduler.sv - round-robin fetch/memory trace framer onto a byte stream.
// Fetch capture is built only when TRACE_FETCH_EN is defined; otherwise memory events only.
module trace_tx_scheduler #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        F_valid,
  input  logic [31:0] F_addr,
  input  logic [31:0] F_instr,
  input  logic [31:0] M_addr,
  input  logic        M_WE,
  input  logic        M_RE,
  input  logic [31:0] M_WData,
  input  logic [31:0] M_RData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] drop_cnt,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic GRANT_MEM   = 1'b0;
  localparam logic GRANT_FETCH = 1'b1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state_q, state_d;
  logic [71:0]   shift_q, shift_d;
  logic [3:0]    idx_q, idx_d;
  logic          last_grant_q, last_grant_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic [16:0]   drop_sum;

  // Memory FIFO entry: {kind[1:0], addr[31:0], data[31:0]}
  logic [65:0]   m_buf_q [DEPTH];
  logic [65:0]   m_buf_d [DEPTH];
  logic [AW-1:0] m_wr_q, m_wr_d, m_rd_q, m_rd_d;
  logic [CW-1:0] m_cnt_q, m_cnt_d;
  logic          m_event, m_push, m_pop, m_drop, m_ne;
  logic [65:0]   m_head;

  logic          f_ne, f_pop, f_drop, grant_fetch;
  logic [63:0]   f_head;

  assign m_event = M_WE | M_RE;
  assign m_ne    = (m_cnt_q != '0);
  assign m_push  = m_event && (m_cnt_q != FULL);
  assign m_drop  = m_event && (m_cnt_q == FULL);
  assign m_head  = m_buf_q[m_rd_q];

`ifdef TRACE_FETCH_EN
  logic [63:0]   f_buf_q [DEPTH];
  logic [63:0]   f_buf_d [DEPTH];
  logic [AW-1:0] f_wr_q, f_wr_d, f_rd_q, f_rd_d;
  logic [CW-1:0] f_cnt_q, f_cnt_d;
  logic          f_push;

  assign f_ne   = (f_cnt_q != '0);
  assign f_push = F_valid && (f_cnt_q != FULL);
  assign f_drop = F_valid && (f_cnt_q == FULL);
  assign f_head = f_buf_q[f_rd_q];

  always_comb begin
    f_buf_d = f_buf_q;
    f_wr_d  = f_wr_q;
    f_rd_d  = f_rd_q;
    if (f_push) begin
      f_buf_d[f_wr_q] = {F_addr, F_instr};
      f_wr_d          = f_wr_q + 1'b1;
    end
    if (f_pop) f_rd_d = f_rd_q + 1'b1;
    f_cnt_d = f_cnt_q + CW'(f_push) - CW'(f_pop);
  end

  always_ff @(posedge clk) begin
    f_buf_q <= f_buf_d;
    if (reset) begin
      f_wr_q  <= '0;
      f_rd_q  <= '0;
      f_cnt_q <= '0;
    end else begin
      f_wr_q  <= f_wr_d;
      f_rd_q  <= f_rd_d;
      f_cnt_q <= f_cnt_d;
    end
  end
`else
  logic unused_fetch;
  assign f_ne         = 1'b0;
  assign f_drop       = 1'b0;
  assign f_head       = '0;
  assign unused_fetch = ^{F_valid, F_addr, F_instr, f_pop};
`endif

  // On a tie the source not served last wins; a lone non-empty source always wins.
  assign grant_fetch = f_ne && (!m_ne || (last_grant_q == GRANT_MEM));

  always_comb begin
    m_buf_d = m_buf_q;
    m_wr_d  = m_wr_q;
    m_rd_d  = m_rd_q;
    if (m_push) begin
      m_buf_d[m_wr_q] = {M_WE, M_RE, M_addr, (M_WE ? M_WData : M_RData)};
      m_wr_d          = m_wr_q + 1'b1;
    end
    if (m_pop) m_rd_d = m_rd_q + 1'b1;
    m_cnt_d    = m_cnt_q + CW'(m_push) - CW'(m_pop);
    drop_sum   = {1'b0, drop_cnt_q} + 17'(m_drop) + 17'(f_drop);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    last_grant_d = last_grant_q;
    m_pop        = 1'b0;
    f_pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (f_ne || m_ne) begin
          state_d = SEND;
          idx_d   = 4'd0;
          if (grant_fetch) begin
            shift_d      = {8'hF0, f_head};
            f_pop        = 1'b1;
            last_grant_d = GRANT_FETCH;
          end else begin
            shift_d      = {8'hA0 | {6'b0, m_head[65:64]}, m_head[63:0]};
            m_pop        = 1'b1;
            last_grant_d = GRANT_MEM;
          end
        end
      end
      SEND: begin
        if (tx_ready) begin
          shift_d = {shift_q[63:0], 8'h00};
          idx_d   = idx_q + 4'd1;
          if (idx_q == 4'd8) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    m_buf_q <= m_buf_d;
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      idx_q        <= '0;
      last_grant_q <= GRANT_MEM;
      drop_cnt_q   <= '0;
      m_wr_q       <= '0;
      m_rd_q       <= '0;
      m_cnt_q      <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      last_grant_q <= last_grant_d;
      drop_cnt_q   <= drop_cnt_d;
      m_wr_q       <= m_wr_d;
      m_rd_q       <= m_rd_d;
      m_cnt_q      <= m_cnt_d;
    end
  end

  // The shift register is all-zero whenever IDLE, so tx_data reads 8'h00 there.
  always_comb begin
    tx_valid = (state_q == SEND);
    tx_data  = shift_q[71:64];
    busy     = (state_q != IDLE) || m_ne || f_ne;
    drop_cnt = drop_cnt_q;
  end

endmodule
